// File: rtl/munoc_tgen_pkg.sv
// munoc_tgen_pkg: shared state encoding, LFSR taps and payload-mode constants for the traffic generator
package munoc_tgen_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
    localparam int unsigned LFSR_TAP_A = 32;
    localparam int unsigned LFSR_TAP_B = 22;
    localparam int unsigned LFSR_TAP_C = 2;
    localparam int unsigned LFSR_TAP_D = 1;
    localparam logic PAT_INC = 1'b0;
    localparam logic PAT_LFSR = 1'b1;
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[LFSR_TAP_A-1] ^ s[LFSR_TAP_B-1] ^ s[LFSR_TAP_C-1] ^ s[LFSR_TAP_D-1]};
    endfunction
endpackage

// File: rtl/munoc_traffic_generator_if.sv
// munoc_traffic_generator_if: one MUNOC valid/ready channel
interface munoc_traffic_generator_if #(
    parameter int unsigned BW_DATA = 32
);
    logic tx_valid;
    logic tx_ready;
    logic tx_last;
    logic [BW_DATA-1:0] tx_data;
    modport master (output tx_valid, tx_data, tx_last, input tx_ready);
    modport slave (input tx_valid, tx_data, tx_last, output tx_ready);
endinterface

// File: rtl/munoc_lfsr32.sv
// munoc_lfsr32: 32-bit Fibonacci LFSR with synchronous load and advance enables
module munoc_lfsr32
    import munoc_tgen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        rstp,
    input  logic        load,
    input  logic        adv,
    output logic [31:0] q
);
    logic [31:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = load ? SEED : adv ? lfsr_next(lfsr_q) : lfsr_q;

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) lfsr_q <= SEED;
        else lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;
endmodule

// File: rtl/munoc_traffic_generator.sv
// munoc_traffic_generator: programmable valid/ready beat initiator with incrementing/LFSR payload and counters
module munoc_traffic_generator
    import munoc_tgen_pkg::*;
#(
    parameter int unsigned BW_DATA   = 32,
    parameter int unsigned BW_COUNT  = 16,
    parameter int unsigned BW_PERIOD = 8,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
    input  logic                 clk,
    input  logic                 rstp,
    input  logic                 start,
    input  logic                 stop,
    input  logic [BW_COUNT-1:0]  cfg_num_beats,
    input  logic [BW_PERIOD-1:0] cfg_period,
    input  logic                 cfg_pattern,
    munoc_traffic_generator_if.master tx,
    output logic                 busy,
    output logic                 done,
    output logic [BW_COUNT-1:0]  sent_count,
    output logic [BW_COUNT-1:0]  stall_cycles
);
    state_t state_q, state_d;
    logic [BW_COUNT-1:0] num_q, sent_q, stall_q;
    logic [BW_PERIOD-1:0] per_q, gap_q, gap_d, eff_p;
    logic [BW_DATA-1:0] inc_q;
    logic [31:0] lfsr_q;
    logic pat_q, load, hs, last_beat;

    assign load = state_q == IDLE && start;
    assign hs = tx.tx_valid && tx.tx_ready;
    assign last_beat = sent_q == num_q - BW_COUNT'(1);
    assign eff_p = (per_q == '0) ? BW_PERIOD'(1) : per_q;

    munoc_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rstp (rstp),
        .load (load),
        .adv  (hs && pat_q == PAT_LFSR),
        .q    (lfsr_q)
    );

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        gap_d = gap_q;
        case (state_q)
            IDLE: state_d = !start ? IDLE : (cfg_num_beats == '0) ? FIN : SEND;
            SEND: if (hs) begin
                state_d = (last_beat || stop) ? FIN : (eff_p == BW_PERIOD'(1)) ? SEND : GAP;
                gap_d = eff_p - BW_PERIOD'(1);
            end
            GAP: begin
                state_d = stop ? FIN : (gap_q == BW_PERIOD'(1)) ? SEND : GAP;
                gap_d = gap_q - BW_PERIOD'(1);
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx.tx_valid = state_q == SEND;
        tx.tx_last = state_q == SEND && last_beat;
        tx.tx_data = (pat_q == PAT_INC) ? inc_q : BW_DATA'(lfsr_q);
        busy = state_q != IDLE;
        done = state_q == FIN;
        sent_count = sent_q;
        stall_cycles = stall_q;
    end

    // Counters hold their final values in IDLE until the next accepted start
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            num_q <= '0;
            per_q <= '0;
            pat_q <= PAT_INC;
            gap_q <= '0;
            sent_q <= '0;
            stall_q <= '0;
            inc_q <= '0;
        end else begin
            gap_q <= gap_d;
            if (load) begin
                num_q <= cfg_num_beats;
                per_q <= cfg_period;
                pat_q <= cfg_pattern;
                sent_q <= '0;
                stall_q <= '0;
                inc_q <= '0;
            end else begin
                if (hs) begin
                    sent_q <= sent_q + BW_COUNT'(1);
                    inc_q <= inc_q + BW_DATA'(1);
                end
                if (tx.tx_valid && !tx.tx_ready && stall_q != '1) stall_q <= stall_q + BW_COUNT'(1);
            end
        end
    end
endmodule

// File: tb/tb_munoc_traffic_generator.sv
// tb_munoc_traffic_generator: cycle model of the main generator plus directed pins and a narrow instance for wrap/saturation
module tb_munoc_traffic_generator;
    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic clk = 1'b0;
    logic rstp = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic start = 1'b0, stop = 1'b0, cfg_pattern = 1'b0, busy, done;
    logic [15:0] cfg_num_beats = '0, sent_count, stall_cycles;
    logic [7:0] cfg_period = '0;
    munoc_traffic_generator_if #(.BW_DATA(32)) tx_if ();

    munoc_traffic_generator dut (
        .clk(clk), .rstp(rstp), .start(start), .stop(stop),
        .cfg_num_beats(cfg_num_beats), .cfg_period(cfg_period), .cfg_pattern(cfg_pattern),
        .tx(tx_if), .busy(busy), .done(done), .sent_count(sent_count), .stall_cycles(stall_cycles)
    );

    logic s_start = 1'b0, s_stop = 1'b0, s_pat = 1'b0, s_busy, s_done;
    logic [4:0] s_n = '0, s_sent, s_stall;
    logic [7:0] s_p = '0;
    munoc_traffic_generator_if #(.BW_DATA(4)) s_if ();

    munoc_traffic_generator #(.BW_DATA(4), .BW_COUNT(5), .BW_PERIOD(8)) dut_s (
        .clk(clk), .rstp(rstp), .start(s_start), .stop(s_stop),
        .cfg_num_beats(s_n), .cfg_period(s_p), .cfg_pattern(s_pat),
        .tx(s_if), .busy(s_busy), .done(s_done), .sent_count(s_sent), .stall_cycles(s_stall)
    );

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [31:0] exp_word(input logic pat, input int k);
        logic [31:0] r = SEED;
        if (!pat) return 32'(k);
        for (int i = 0; i < k; i++) r = step(r);
        return r;
    endfunction

    // Model: a run is a sequence of beats; beat k carries word k and the next valid follows a handshake by P cycles
    logic m_busy = 0, m_valid = 0, m_done = 0, m_pat = 0;
    int m_n = 0, m_p = 1, m_sent = 0, m_stall = 0, m_next = 0;
    logic [31:0] hs_data[$];
    int hs_cyc[$];
    int done_cyc = -1, start_cyc = 0;

    initial forever begin
        @(negedge clk);
        if (rstp) begin
            m_busy = 0; m_valid = 0; m_done = 0; m_sent = 0; m_stall = 0; m_n = 0; m_pat = 0;
        end
        chk("valid", tx_if.tx_valid, m_valid);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("sent", sent_count, m_sent);
        chk("stall", stall_cycles, m_stall);
        chk("last", tx_if.tx_last, m_valid && m_sent == m_n - 1);
        if (m_valid) chk("data", tx_if.tx_data, exp_word(m_pat, m_sent));
        if (tx_if.tx_valid && tx_if.tx_ready) begin
            hs_data.push_back(tx_if.tx_data);
            hs_cyc.push_back(cyc);
        end
        if (done) done_cyc = cyc;
        if (!rstp) begin
            if (m_done) begin
                m_done = 0; m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_n = int'(cfg_num_beats); m_p = (cfg_period == 0) ? 1 : int'(cfg_period);
                    m_pat = cfg_pattern; m_sent = 0; m_stall = 0; m_busy = 1;
                    m_done = (m_n == 0); m_valid = (m_n != 0);
                end
            end else if (m_valid) begin
                if (tx_if.tx_ready) begin
                    m_sent++;
                    m_next = cyc + m_p;
                    m_done = (m_sent == m_n) || stop;
                    m_valid = !m_done && (m_next == cyc + 1);
                end else if (m_stall < 65535) m_stall++;
            end else if (stop) m_done = 1;
            else m_valid = (m_next == cyc + 1);
        end
    end

    function automatic logic [31:0] hd(input int i);
        return (i < hs_data.size()) ? hs_data[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic int hc(input int i);
        return (i < hs_cyc.size()) ? hs_cyc[i] : -1000;
    endfunction

    task automatic run(input int n, input int p, input logic pat, input logic stp);
        @(posedge clk); #1;
        hs_data.delete(); hs_cyc.delete(); done_cyc = -1;
        cfg_num_beats = 16'(n); cfg_period = 8'(p); cfg_pattern = pat; stop = stp;
        start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        chk({nm, "_idle"}, busy, 0);
    endtask

    initial begin
        tx_if.tx_ready = 1'b1;
        s_if.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstp = 1'b0;
        chk("rst_data", tx_if.tx_data, 0);
        chk("rst_valid", tx_if.tx_valid, 0);
        chk("rst_stall", stall_cycles, 0);

        run(4, 1, 0, 0);
        wait_idle("b2b");
        chk("b2b_beats", hs_data.size(), 4);
        for (int i = 0; i < 4; i++) chk("b2b_data", hd(i), 32'(i));
        chk("b2b_first", hc(0), start_cyc + 1);
        chk("b2b_span", hc(3) - hc(0), 3);
        chk("b2b_done", done_cyc, hc(3) + 1);
        chk("b2b_sent", sent_count, 4);
        chk("b2b_stall", stall_cycles, 0);

        run(3, 4, 0, 0);
        wait_idle("thr");
        chk("thr_gap1", hc(1) - hc(0), 4);
        chk("thr_gap2", hc(2) - hc(1), 4);

        run(3, 0, 0, 0);
        wait_idle("p0");
        chk("p0_span", hc(2) - hc(0), 2);

        tx_if.tx_ready = 1'b0;
        run(2, 1, 1, 0);
        repeat (5) @(posedge clk);
        #1 tx_if.tx_ready = 1'b1;
        wait_idle("bp");
        chk("bp_beat0", hd(0), 32'hACE1_0001);
        chk("bp_beat1", hd(1), 32'h59C2_0003);
        chk("bp_stall", stall_cycles, 5);

        run(100, 8, 0, 0);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (sent_count == 3) begin
                stop = 1'b1;
                break;
            end
        end
        wait_idle("estop");
        stop = 1'b0;
        chk("estop_sent", sent_count, 3);
        chk("estop_done", done_cyc, hc(2) + 2);

        tx_if.tx_ready = 1'b0;
        run(5, 1, 0, 1);
        repeat (2) @(posedge clk);
        #1 tx_if.tx_ready = 1'b1;
        wait_idle("sstop");
        stop = 1'b0;
        chk("sstop_sent", sent_count, 1);
        chk("sstop_stall", stall_cycles, 2);

        run(0, 1, 0, 0);
        wait_idle("zero");
        chk("zero_done", done_cyc, start_cyc + 1);
        chk("zero_beats", hs_data.size(), 0);

        run(10, 1, 1, 0);
        repeat (2) @(posedge clk);
        #1 rstp = 1'b1;
        #1;
        chk("arst_valid", tx_if.tx_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sent", sent_count, 0);
        chk("arst_data", tx_if.tx_data, 0);
        @(posedge clk); #1 rstp = 1'b0;
        run(2, 1, 1, 0);
        wait_idle("rs_lfsr");
        chk("rs_lfsr_beat0", hd(0), 32'hACE1_0001);
        run(2, 1, 0, 0);
        wait_idle("rs_inc");
        chk("rs_inc_beat0", hd(0), 0);

        begin
            int k = 0;
            @(posedge clk); #1;
            s_n = 5'd18; s_p = 8'd1; s_pat = 1'b0; s_if.tx_ready = 1'b1; s_start = 1'b1;
            @(posedge clk); #1 s_start = 1'b0;
            for (int i = 0; i < 40 && k < 18; i++) begin
                @(negedge clk);
                if (s_if.tx_valid && s_if.tx_ready) begin
                    chk("wrap_data", 32'(s_if.tx_data), 32'(k % 16));
                    chk("wrap_last", s_if.tx_last, k == 17);
                    k++;
                end
            end
            chk("wrap_beats", k, 18);
            repeat (4) @(posedge clk);
            #1;
            chk("wrap_busy", s_busy, 0);
            chk("wrap_sent", s_sent, 18);
        end

        s_n = 5'd1; s_if.tx_ready = 1'b0; s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("sat_mid", s_stall, 10);
        repeat (30) @(posedge clk);
        #1 chk("sat_full", s_stall, 5'h1F);
        s_if.tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("sat_hold", s_stall, 5'h1F);
        chk("sat_sent", s_sent, 1);
        chk("sat_busy", s_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/munoc_traffic_generator.md
# munoc_traffic_generator

Synthetic initiator for one MUNOC valid/ready channel. It drives a programmed number of beats at a programmed issue period, with incrementing or LFSR payload, and reports sent-beat and stall counts. It is the transmitting end paired with the channel timeout/bandwidth monitor, used in bring-up and NoC stress benches.

## Interface
Parameters:
- BW_DATA, 32, payload width; legal range 1..32.
- BW_COUNT, 16, width of the beat count, sent count and stall count.
- BW_PERIOD, 8, width of the issue-period field.
- LFSR_SEED, 32'hACE1_0001, LFSR value loaded at start; must be nonzero.

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- rstp, input, 1, reset; asynchronous, active-high.
- start, input, 1, one-cycle request to begin a run; honoured only in IDLE.
- stop, input, 1, request to end the run early; level-sampled.
- cfg_num_beats, input, BW_COUNT, number of beats in the run; sampled at start.
- cfg_period, input, BW_PERIOD, cycles from one handshake to the next valid; sampled at start.
- cfg_pattern, input, 1, payload mode: 0 = incrementing, 1 = LFSR; sampled at start.
- tx_valid, output, 1, channel valid.
- tx_ready, input, 1, channel ready.
- tx_data, output, BW_DATA, channel payload.
- tx_last, output, 1, high with the final beat of the run.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse at the end of a run.
- sent_count, output, BW_COUNT, number of handshakes in the current or last run.
- stall_cycles, output, BW_COUNT, number of cycles with tx_valid high and tx_ready low; saturates at all-ones.

## Operation
- States are IDLE, SEND, GAP and FIN.
- IDLE:
  - On start, latch the cfg_* inputs, clear sent_count and stall_cycles, load the payload generator.
  - Incrementing mode loads 0. LFSR mode loads LFSR_SEED.
  - Go to FIN if cfg_num_beats==0; otherwise go to SEND.
- SEND:
  - tx_valid=1.
  - Handshake is tx_valid&tx_ready. On handshake, sent_count increments and the generator advances.
  - Incrementing mode adds +1, wrapping modulo 2^BW_DATA.
  - LFSR mode uses lfsr_next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
  - After a handshake:
    - Go to FIN if that beat was the last beat or stop is high.
    - Otherwise go to SEND if the effective period is 1.
    - Otherwise go to GAP with the gap counter set to period-1.
  - Without a handshake, stay in SEND. stop does not abort a pending beat.
- Effective period: cfg_period==0 is treated as 1.
- GAP:
  - tx_valid=0. The counter decrements each cycle.
  - When the counter reaches 1, go to SEND.
  - stop high → go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- Payload:
  - tx_data is the generator register. In LFSR mode it is the low BW_DATA bits.
  - tx_data must be held stable while tx_valid&~tx_ready.
- tx_last = tx_valid & (sent_count == num_beats_latched-1).
- tx_valid never drops without a handshake, except under rstp.
- start outside IDLE is ignored. start and stop in the same IDLE cycle: start wins, and stop is then seen in SEND.
- Counters keep their final values in IDLE until the next start.

## Timing
- Reset values: state=IDLE; tx_valid, tx_last, busy, done = 0; tx_data=0; sent_count=0; stall_cycles=0; LFSR register=LFSR_SEED.
- rstp mid-run: tx_valid deasserts asynchronously. No done pulse is produced.
- start at cycle N gives tx_valid=1 at N+1.
- A handshake at cycle M with effective period P gives the next tx_valid at M+P.
- A handshake on the last beat at cycle M gives done at M+1 and busy=0 at M+2.
- With cfg_num_beats==0, start at N gives done at N+1.
- sent_count and stall_cycles update on the edge after the sampled cycle.

## Structure
- Shared package munoc_tgen_pkg holds:
  - the state encoding;
  - the LFSR tap constants (32, 22, 2, 1);
  - the pattern-mode constants.
- One sub-module, munoc_lfsr32, holds the 32-bit Fibonacci LFSR, with load and advance enables.
- Everything else stays in the top module.

## Test plan
- Back-to-back run: num_beats=4, period=1, pattern=0, tx_ready=1.
  - tx_valid high for 4 consecutive cycles, data 0,1,2,3.
  - tx_last only on data 3; done one cycle later; sent_count=4; stall_cycles=0.
- Throttled run: num_beats=3, period=4.
  - Handshakes exactly 4 cycles apart.
  - tx_valid low for 3 cycles between beats.
- Backpressure: tx_ready low for 5 cycles on beat 1 (num_beats=2, pattern=1).
  - tx_data holds at 32'hACE1_0001.
  - stall_cycles=5; the second beat is lfsr_next(seed).
- Early stop: num_beats=100, period=8, stop raised during GAP after beat 2.
  - FIN next cycle; sent_count=3.
  - Raising stop while in SEND instead completes the pending beat first.
- Boundary run: num_beats=0 gives done at N+1 with no tx_valid.
  - Incrementing payload with BW_DATA=4 and 18 beats wraps 15→0.
  - Saturation: stall forced for more than 2^BW_COUNT cycles holds stall_cycles at all-ones.
- Reset mid-run: rstp asserted in SEND.
  - Outputs drop to reset values immediately.
  - A subsequent start restarts from data 0 and LFSR_SEED.
